// File: rtl/msp430_pipeline.sv
// -----------------------------------------------------------------------------
// msp430_pipeline
// Simplified MSP430 CPU core: FETCH -> (EXT) -> EXEC sequencer, 16x16
// register file (R0=PC, R1=SP, R2=SR, R3=constant generator) and an ALU
// with flag logic. Instruction and immediate words come from program memory
// over a read-only bus. The core never writes to memory.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   MDB_in     memory data bus, word at MAB_out
//   RST_VEC    PC load value on reset
//   reg_SP_in  SP (R1) load value on reset
//   reg_SR_in  SR (R2) load value on reset
//   MAB_out    memory address bus (always the PC)
//   pc_out     R0
//   sp_out     R1
//   sr_out     R2
//   regs_out   R15..R0 concatenated, Rn at [16n+15:16n]
// -----------------------------------------------------------------------------
module msp430_pipeline (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  MDB_in,
  input  logic [15:0]  RST_VEC,
  input  logic [15:0]  reg_SP_in,
  input  logic [15:0]  reg_SR_in,
  output logic [15:0]  MAB_out,
  output logic [15:0]  pc_out,
  output logic [15:0]  sp_out,
  output logic [15:0]  sr_out,
  output logic [255:0] regs_out
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXT   = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [15:0] ir_q, ir_d;
  logic [15:0] imm_q, imm_d;

  // Sign bit of an operand in word or byte mode.
  function automatic logic msb_of(input logic [15:0] x, input logic bw);
    return bw ? x[7] : x[15];
  endfunction

  // Instruction fields (Format I and Format III share the same IR).
  logic [3:0] opcode, src_reg, dst_reg;
  logic       ad_bit, bw_bit, fmt1, is_jump, fetch_imm;
  logic [1:0] as_mode;
  logic [2:0] jcond;
  logic [15:0] jmp_off;

  assign opcode   = ir_q[15:12];
  assign src_reg  = ir_q[11:8];
  assign ad_bit   = ir_q[7];
  assign bw_bit   = ir_q[6];
  assign as_mode  = ir_q[5:4];
  assign dst_reg  = ir_q[3:0];
  assign jcond    = ir_q[12:10];
  assign fmt1     = (opcode >= 4'h4);
  assign is_jump  = (ir_q[15:13] == 3'b001);
  // Word offset sign-extended and doubled into a byte displacement.
  assign jmp_off  = {{5{ir_q[9]}}, ir_q[9:0], 1'b0};
  // Only the @PC+ source with a register destination pulls an extension word.
  assign fetch_imm = (MDB_in[15:12] >= 4'h4) && !MDB_in[7] &&
                     (MDB_in[5:4] == 2'b11) && (MDB_in[11:8] == 4'h0);

  logic [15:0] src_val;
  logic        src_ok;

  // Source operand: register, immediate or constant generator (R2/R3).
  always_comb begin
    src_val = 16'h0000;
    src_ok  = 1'b0;
    case (as_mode)
      2'b00: begin
        src_ok = 1'b1;
        if (src_reg == 4'd3) src_val = 16'h0000;
        else                 src_val = regs_q[src_reg];
      end
      2'b01: begin
        if (src_reg == 4'd3) begin src_val = 16'h0001; src_ok = 1'b1; end
        else                 begin src_val = 16'h0000; src_ok = 1'b0; end
      end
      2'b10: begin
        if (src_reg == 4'd3)      begin src_val = 16'h0002; src_ok = 1'b1; end
        else if (src_reg == 4'd2) begin src_val = 16'h0004; src_ok = 1'b1; end
        else                      begin src_val = 16'h0000; src_ok = 1'b0; end
      end
      2'b11: begin
        if (src_reg == 4'd0)      begin src_val = imm_q;    src_ok = 1'b1; end
        else if (src_reg == 4'd3) begin src_val = 16'hFFFF; src_ok = 1'b1; end
        else if (src_reg == 4'd2) begin src_val = 16'h0008; src_ok = 1'b1; end
        else                      begin src_val = 16'h0000; src_ok = 1'b0; end
      end
      default: begin
        src_val = 16'h0000;
        src_ok  = 1'b0;
      end
    endcase
  end

  // Operands are zero-extended from bit 7 in byte mode so results come out
  // with the upper byte already cleared.
  logic [15:0] a_op, b_op, binv_op, add_b, add_res, res;
  logic [16:0] add_sum;
  logic        add_cin, add_c, add_v;
  logic        cout, vout, zout, nout, wr_op, fl_op, exec_ok;

  assign a_op    = bw_bit ? {8'h00, regs_q[dst_reg][7:0]} : regs_q[dst_reg];
  assign b_op    = bw_bit ? {8'h00, src_val[7:0]} : src_val;
  assign binv_op = bw_bit ? {8'h00, ~src_val[7:0]} : ~src_val;
  assign exec_ok = fmt1 && !ad_bit && src_ok;

  // Shared adder for ADD/ADDC/SUB/SUBC/CMP.
  always_comb begin
    if (opcode == 4'h7 || opcode == 4'h8 || opcode == 4'h9) add_b = binv_op;
    else                                                    add_b = b_op;
    if (opcode == 4'h5)                           add_cin = 1'b0;
    else if (opcode == 4'h8 || opcode == 4'h9)    add_cin = 1'b1;
    else                                          add_cin = regs_q[2][0];
    add_sum = {1'b0, a_op} + {1'b0, add_b} + {16'h0000, add_cin};
    add_res = bw_bit ? {8'h00, add_sum[7:0]} : add_sum[15:0];
    add_c   = bw_bit ? add_sum[8] : add_sum[16];
    add_v   = (msb_of(a_op, bw_bit) == msb_of(add_b, bw_bit)) &&
              (msb_of(add_res, bw_bit) != msb_of(a_op, bw_bit));
  end

  // ALU result, flag values and write/flag enables per opcode.
  always_comb begin
    res   = 16'h0000;
    cout  = 1'b0;
    vout  = 1'b0;
    wr_op = 1'b0;
    fl_op = 1'b0;
    case (opcode)
      4'h4: begin res = b_op; wr_op = 1'b1; end
      4'h5, 4'h6, 4'h7, 4'h8: begin
        res = add_res; cout = add_c; vout = add_v; wr_op = 1'b1; fl_op = 1'b1;
      end
      4'h9: begin res = add_res; cout = add_c; vout = add_v; fl_op = 1'b1; end
      4'hB: begin res = a_op & b_op; cout = |(a_op & b_op); fl_op = 1'b1; end
      4'hC: begin res = a_op & binv_op; wr_op = 1'b1; end
      4'hD: begin res = a_op | b_op; wr_op = 1'b1; end
      4'hE: begin
        res = a_op ^ b_op; cout = |(a_op ^ b_op);
        vout = msb_of(a_op, bw_bit) & msb_of(b_op, bw_bit);
        wr_op = 1'b1; fl_op = 1'b1;
      end
      4'hF: begin
        res = a_op & b_op; cout = |(a_op & b_op); wr_op = 1'b1; fl_op = 1'b1;
      end
      default: begin
        res = 16'h0000; wr_op = 1'b0; fl_op = 1'b0;
      end
    endcase
    zout = (res == 16'h0000);
    nout = msb_of(res, bw_bit);
  end

  logic jmp_take;

  // Jump condition evaluated against the current SR flags.
  always_comb begin
    case (jcond)
      3'd0:    jmp_take = !regs_q[2][1];
      3'd1:    jmp_take = regs_q[2][1];
      3'd2:    jmp_take = !regs_q[2][0];
      3'd3:    jmp_take = regs_q[2][0];
      3'd4:    jmp_take = regs_q[2][2];
      3'd5:    jmp_take = (regs_q[2][2] == regs_q[2][8]);
      3'd6:    jmp_take = (regs_q[2][2] != regs_q[2][8]);
      3'd7:    jmp_take = 1'b1;
      default: jmp_take = 1'b0;
    endcase
  end

  // Sequencer next state and register-file writeback.
  always_comb begin
    regs_d  = regs_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        ir_d       = MDB_in;
        regs_d[0]  = regs_q[0] + 16'd2;
        state_d    = fetch_imm ? ST_EXT : ST_EXEC;
      end
      ST_EXT: begin
        imm_d      = MDB_in;
        regs_d[0]  = regs_q[0] + 16'd2;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_jump) begin
          if (jmp_take) regs_d[0] = regs_q[0] + jmp_off;
          else          regs_d[0] = regs_q[0];
        end else if (exec_ok) begin
          if (fl_op) regs_d[2] = {regs_q[2][15:9], vout, regs_q[2][7:3], nout, zout, cout};
          else       regs_d[2] = regs_q[2];
          // Destination write comes last so a write to SR overrides flags.
          if (wr_op) begin
            if (dst_reg == 4'd0)      regs_d[0] = {res[15:1], 1'b0};
            else if (dst_reg == 4'd3) regs_d[3] = regs_q[3];
            else                      regs_d[dst_reg] = res;
          end else begin
            regs_d[dst_reg] = regs_d[dst_reg];
          end
        end else begin
          regs_d = regs_q;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 16'h0000;
      regs_q[0] <= RST_VEC;
      regs_q[1] <= reg_SP_in;
      regs_q[2] <= reg_SR_in;
      ir_q      <= 16'h0000;
      imm_q     <= 16'h0000;
      state_q   <= ST_FETCH;
    end else begin
      regs_q  <= regs_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      state_q <= state_d;
    end
  end

  // Outputs are straight views of the register file.
  always_comb begin
    for (int i = 0; i < 16; i++) regs_out[16*i +: 16] = regs_q[i];
  end
  assign MAB_out = regs_q[0];
  assign pc_out  = regs_q[0];
  assign sp_out  = regs_q[1];
  assign sr_out  = regs_q[2];

endmodule

// File: tb/tb_msp430_pipeline.sv
// -----------------------------------------------------------------------------
// tb_msp430_pipeline
// Directed bench for msp430_pipeline: a table of short programs run from reset
// with hand-computed register/SR/PC results, plus hand-written sequences for
// reset, the NOP stream, a jump-to-self loop and reset during EXT.
// -----------------------------------------------------------------------------
module tb_msp430_pipeline;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  MDB_in, RST_VEC, reg_SP_in, reg_SR_in;
  logic [15:0]  MAB_out, pc_out, sp_out, sr_out;
  logic [255:0] regs_out;

  msp430_pipeline dut (
    .clk(clk), .rst(rst), .MDB_in(MDB_in), .RST_VEC(RST_VEC),
    .reg_SP_in(reg_SP_in), .reg_SR_in(reg_SR_in), .MAB_out(MAB_out),
    .pc_out(pc_out), .sp_out(sp_out), .sr_out(sr_out), .regs_out(regs_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] w0, w1, w2;
    int          ncyc;
    logic [15:0] sr_in;
    int          ridx;
    logic [15:0] rexp, srexp, pcexp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t        vecs [NVEC];
  logic [15:0] prog [8];
  int          checks = 0;
  int          errors = 0;

  // Program memory starting at 0xC000; everything else reads as 0 (NOP).
  function automatic logic [15:0] mem_rd(input logic [15:0] addr);
    logic [15:0] off;
    off = addr - 16'hC000;
    if (off < 16'd16) return prog[off[3:1]];
    else              return 16'h0000;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    MDB_in = mem_rd(MAB_out);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < 8; i++) prog[i] = 16'h0000;
    prog[0] = w0; prog[1] = w1; prog[2] = w2;
  endtask

  task automatic do_reset(input logic [15:0] sr_in);
    RST_VEC = 16'hC000; reg_SP_in = 16'h0400; reg_SR_in = sr_in;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    //            name               w0       w1       w2       cyc sr_in    r   rexp     srexp    pcexp
    vecs[0]  = '{"mov_imm",        16'h4035,16'h1234,16'h0000, 3, 16'h0000, 5, 16'h1234,16'h0000,16'hC004};
    vecs[1]  = '{"add_flags",      16'h4035,16'h8000,16'h5505, 5, 16'h0000, 5, 16'h0000,16'h0103,16'hC006};
    vecs[2]  = '{"addb_carry",     16'h4036,16'h12FF,16'h5356, 5, 16'h0000, 6, 16'h0000,16'h0003,16'hC006};
    vecs[3]  = '{"sub_neg",        16'h4037,16'h0005,16'h8237, 5, 16'h0000, 7, 16'hFFFD,16'h0004,16'hC006};
    vecs[4]  = '{"xor_self",       16'h4338,16'hE808,16'h0000, 4, 16'h0000, 8, 16'h0000,16'h0102,16'hC004};
    vecs[5]  = '{"bit_nowrite",    16'h4229,16'hB229,16'h0000, 4, 16'h0000, 9, 16'h0004,16'h0001,16'hC004};
    vecs[6]  = '{"sr_dst_override",16'h5322,16'h0000,16'h0000, 2, 16'h0001, 2, 16'h0003,16'h0003,16'hC002};
    vecs[7]  = '{"subc_c0",        16'h730A,16'h0000,16'h0000, 2, 16'h0000,10, 16'hFFFF,16'h0004,16'hC002};
    vecs[8]  = '{"subc_c1",        16'h730A,16'h0000,16'h0000, 2, 16'h0001,10, 16'h0000,16'h0003,16'hC002};
    vecs[9]  = '{"addc",           16'h631B,16'h0000,16'h0000, 2, 16'h0001,11, 16'h0002,16'h0000,16'hC002};
    vecs[10] = '{"r3_ignored",     16'h4333,16'h0000,16'h0000, 2, 16'h0004, 3, 16'h0000,16'h0004,16'hC002};
    vecs[11] = '{"branch_bit0",    16'h4030,16'hC101,16'h0000, 3, 16'h0000, 0, 16'hC100,16'h0000,16'hC100};
    vecs[12] = '{"jeq_not_taken",  16'h27FF,16'h0000,16'h0000, 2, 16'h0000, 0, 16'hC002,16'h0000,16'hC002};
    vecs[13] = '{"jeq_taken",      16'h27FF,16'h0000,16'h0000, 2, 16'h0002, 0, 16'hC000,16'h0002,16'hC000};
    vecs[14] = '{"jmp_fwd",        16'h3C03,16'h0000,16'h0000, 2, 16'h0000, 0, 16'hC008,16'h0000,16'hC008};
    vecs[15] = '{"jl_taken",       16'h3BFF,16'h0000,16'h0000, 2, 16'h0004, 0, 16'hC000,16'h0004,16'hC000};
    vecs[16] = '{"indexed_nop",    16'h4515,16'h0000,16'h0000, 2, 16'h0000, 5, 16'h0000,16'h0000,16'hC002};
    vecs[17] = '{"bic",            16'h433C,16'hC23C,16'h0000, 4, 16'h0000,12, 16'hFFF7,16'h0000,16'hC004};
    vecs[18] = '{"movb",           16'h437D,16'h0000,16'h0000, 2, 16'h0000,13, 16'h00FF,16'h0000,16'hC002};
    vecs[19] = '{"dadd_nop",       16'h4035,16'h0007,16'hA505, 5, 16'h0000, 5, 16'h0007,16'h0000,16'hC006};

    rst = 1'b0; MDB_in = 16'h0000;
    RST_VEC = 16'hC000; reg_SP_in = 16'h0400; reg_SR_in = 16'h0000;

    // Reset values.
    load(16'h0000, 16'h0000, 16'h0000);
    do_reset(16'h0000);
    check16("rst_pc", pc_out, 16'hC000);
    check16("rst_mab", MAB_out, 16'hC000);
    check16("rst_sp", sp_out, 16'h0400);
    check16("rst_sr", sr_out, 16'h0000);
    checks++;
    if (regs_out[255:48] !== 208'h0) begin
      errors++;
      $display("FAIL rst_r3_r15 actual=%h expected=0", regs_out[255:48]);
    end

    // NOP stream: one instruction every 2 cycles.
    step();
    check16("nop_pc_c1", pc_out, 16'hC002);
    step();
    check16("nop_pc_c2", pc_out, 16'hC002);
    for (int i = 0; i < 8; i++) step();
    check16("nop_pc_c10", pc_out, 16'hC00A);
    check16("nop_sr", sr_out, 16'h0000);
    check16("nop_sp", sp_out, 16'h0400);

    // Table-driven programs.
    for (int v = 0; v < NVEC; v++) begin
      load(vecs[v].w0, vecs[v].w1, vecs[v].w2);
      do_reset(vecs[v].sr_in);
      for (int c = 0; c < vecs[v].ncyc; c++) step();
      check16({vecs[v].name, "_reg"}, regs_out[16*vecs[v].ridx +: 16], vecs[v].rexp);
      check16({vecs[v].name, "_sr"}, sr_out, vecs[v].srexp);
      check16({vecs[v].name, "_pc"}, pc_out, vecs[v].pcexp);
    end

    // JMP $ keeps returning to 0xC000.
    load(16'h3FFF, 16'h0000, 16'h0000);
    do_reset(16'h0000);
    step();
    check16("jmp_self_fetch", pc_out, 16'hC002);
    step();
    check16("jmp_self_1", pc_out, 16'hC000);
    step(); step();
    check16("jmp_self_2", pc_out, 16'hC000);

    // Reset during EXT of MOV #0x1234,R5.
    load(16'h4035, 16'h1234, 16'h0000);
    do_reset(16'h0000);
    step();
    check16("midrst_pre_pc", pc_out, 16'hC002);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check16("midrst_pc", pc_out, 16'hC000);
    check16("midrst_r5", regs_out[16*5 +: 16], 16'h0000);
    step(); step(); step();
    check16("midrst_refetch_r5", regs_out[16*5 +: 16], 16'h1234);
    check16("midrst_refetch_pc", pc_out, 16'hC004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msp430_pipeline.md
Name: msp430_pipeline

Overview:
Simplified MSP430 CPU core: fetch/extension/execute sequencer, 16x16 register file and ALU with flag logic.
- Reads instruction and immediate words from program memory over a read-only bus (MAB_out address, MDB_in data).
- Sits between program memory and the rest of the MSP430 model.
- No data-memory writes.

Parameters:
None.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
MDB_in  input  16  memory data bus; word at MAB_out, sampled at rising edge
RST_VEC  input  16  PC load value on reset
reg_SP_in  input  16  SP (R1) load value on reset
reg_SR_in  input  16  SR (R2) load value on reset
MAB_out  output  16  memory address bus; always equals PC
pc_out  output  16  R0
sp_out  output  16  R1
sr_out  output  16  R2
regs_out  output  256  R15..R0 concatenated, Rn at [16n+15:16n]

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset (rst=1 at a rising edge) loads:
  - PC=RST_VEC, SP=reg_SP_in, SR=reg_SR_in.
  - R3..R15=0, IR=0, state=FETCH.
  - Reset overrides any state, including mid-instruction.
- State machine: FETCH -> (EXT) -> EXEC -> FETCH.
- FETCH: IR<=MDB_in; PC<=PC+2. Go to EXT if source is immediate, else EXEC.
- EXT: source operand<=MDB_in; PC<=PC+2; go to EXEC.
- EXEC: perform the operation, write back, go to FETCH.
- Latency: register/constant-source instruction = 2 cycles; immediate = 3 cycles.
- Format I (IR[15:12]=4..F): src=IR[11:8], Ad=IR[7], B/W=IR[6], As=IR[5:4], dst=IR[3:0].
  - Supported: Ad=0 only.
  - Source modes:
    - As=00: Rn (R0 reads the already-incremented PC).
    - As=11 with src=R0: immediate.
    - Constant generator R3: As=00->0, 01->1, 10->2, 11->0xFFFF.
    - Constant generator R2: As=10->4, 11->8.
  - Any other mode, or Ad=1: NOP (no register/flag change, one EXEC cycle).
- Opcodes: 4 MOV, 5 ADD, 6 ADDC, 7 SUBC, 8 SUB, 9 CMP, A DADD (treated as NOP), B BIT, C BIC, D BIS, E XOR, F AND.
  - SUB = dst+~src+1; SUBC = dst+~src+C; ADDC = dst+src+C.
  - CMP = SUB without write; BIT = AND without write.
- Flags (SR bits C=0, Z=1, N=2, V=8):
  - ADD/ADDC/SUB/SUBC/CMP: C=carry out, Z=(result==0), N=MSB, V=signed overflow.
  - AND/BIT: N, Z, C=~Z, V=0.
  - XOR: N, Z, C=~Z, V=(src MSB & dst MSB).
  - MOV/BIC/BIS: flags unchanged.
- Byte op (B/W=1): operate on low 8 bits; MSB is bit 7, carry is out of bit 7; register destination upper byte cleared.
- Writeback rules:
  - Write to R3 ignored.
  - Write to R2 as destination overrides flag update in that cycle.
  - Write to R0 is a branch: next FETCH uses the new PC; bit 0 forced to 0.
- Format III (IR[15:13]=001): cond=IR[12:10], offset=IR[9:0] sign-extended.
  - If taken, in EXEC: PC<=PC+2*offset (PC already points past the instruction).
  - Conditions: 0 JNE (Z=0), 1 JEQ (Z=1), 2 JNC (C=0), 3 JC (C=1), 4 JN (N=1), 5 JGE (N==V), 6 JL (N!=V), 7 JMP (always).
  - Not taken: no change.
- All other encodings (including 0x0000 and Format II): NOP, 2 cycles.
- PC arithmetic wraps modulo 2^16 (0xFFFE+2=0x0000).

Test Plan:
- Reset: rst=1, RST_VEC=0xC000, reg_SP_in=0x0400, reg_SR_in=0 -> after edge pc_out=MAB_out=0xC000, sp_out=0x0400, sr_out=0, regs R3..R15=0.
- NOP stream: MDB_in=0 held, rst released -> PC advances by 2 every 2 cycles; PC=0xC00A after 10 cycles; registers/SR unchanged.
- Immediate: MDB_in=0x4035 then 0x1234 (MOV #0x1234,R5) -> R5=0x1234 after 3 cycles, PC+4, SR unchanged.
- ALU flags: R5=0x8000, execute 0x5505 (ADD R5,R5) -> R5=0x0000, SR C=1, Z=1, V=1, N=0.
- Jump: 0x3FFF (JMP $) at 0xC000 -> PC returns to 0xC000 every 2 cycles. Also JEQ with Z=0 -> falls through to 0xC002.
- Reset mid-instruction: assert rst during EXT of a MOV immediate -> PC=RST_VEC, destination unmodified, state FETCH.
